// File: rtl/collatz_engine.sv
// Iterative Collatz trajectory engine: one step per clock, reports orbit length,
// peak value, and overflow of either the working value or the step counter.
module collatz_engine #(
  parameter int unsigned BITS     = 32,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BITS-1:0]     number,
  output logic                busy,
  output logic                done,
  output logic [LEN_BITS-1:0] orbit_len,
  output logic [BITS-1:0]     path_record,
  output logic                overflow,
  output logic                err
);

  localparam int unsigned WIDE = BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     n_q, n_d;
  logic [BITS-1:0]     rec_q, rec_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic [WIDE-1:0]     triple;
  logic [BITS-1:0]     step_n;
  logic                len_sat;
  logic                triple_ovf;

  // Candidate next value; 3n+1 is formed two bits wider so its overflow is visible
  always_comb begin
    triple     = WIDE'(n_q) + WIDE'({n_q, 1'b0}) + WIDE'(1);
    triple_ovf = (triple[WIDE-1:BITS] != '0);
    step_n     = n_q[0] ? triple[BITS-1:0] : (n_q >> 1);
    len_sat    = (len_q == {LEN_BITS{1'b1}});
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rec_d   = rec_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d = '0;
          ovf_d = 1'b0;
          if (number == '0) begin
            state_d = DONE;
            n_d     = '0;
            rec_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            n_d     = number;
            rec_d   = number;
            err_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (n_q == BITS'(1)) begin
          state_d = DONE;
        end else if (len_sat || (n_q[0] && triple_ovf)) begin
          // Result would be unrepresentable: freeze n, length and record
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          n_d   = step_n;
          len_d = len_q + LEN_BITS'(1);
          if (step_n > rec_q) begin
            rec_d = step_n;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      rec_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rec_q   <= rec_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign orbit_len   = len_q;
  assign path_record = rec_q;
  assign overflow    = ovf_q;
  assign err         = err_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Scoreboard bench for collatz_engine: three parameterisations share clock and
// reset; each has its own expected-result queue and monitor.
module tb_collatz_engine;

  typedef struct {
    longint unsigned len;
    longint unsigned rec;
    bit              ovf;
    bit              err;
    int              lat;
  } exp_t;

  localparam int BITS_C [3]  = '{32, 8, 32};
  localparam int LBITS_C [3] = '{16, 4, 4};

  logic clk;
  logic rst_n;
  logic start_v [3];
  longint unsigned num_v [3];
  bit   acc_v [3];

  logic busy_w [3];
  logic done_w [3];
  logic ovf_w [3];
  logic err_w [3];
  longint unsigned len_w [3];
  longint unsigned rec_w [3];

  logic [31:0] num_a, num_c, rec_a, rec_c;
  logic [7:0]  num_b, rec_b;
  logic [15:0] len_a;
  logic [3:0]  len_b, len_c;

  int checks = 0;
  int errors = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  assign num_a = num_v[0][31:0];
  assign num_b = num_v[1][7:0];
  assign num_c = num_v[2][31:0];
  assign len_w[0] = 64'(len_a);
  assign len_w[1] = 64'(len_b);
  assign len_w[2] = 64'(len_c);
  assign rec_w[0] = 64'(rec_a);
  assign rec_w[1] = 64'(rec_b);
  assign rec_w[2] = 64'(rec_c);

  collatz_engine #(.BITS(32), .LEN_BITS(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .number(num_a),
    .busy(busy_w[0]), .done(done_w[0]), .orbit_len(len_a),
    .path_record(rec_a), .overflow(ovf_w[0]), .err(err_w[0]));

  collatz_engine #(.BITS(8), .LEN_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .number(num_b),
    .busy(busy_w[1]), .done(done_w[1]), .orbit_len(len_b),
    .path_record(rec_b), .overflow(ovf_w[1]), .err(err_w[1]));

  collatz_engine #(.BITS(32), .LEN_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .number(num_c),
    .busy(busy_w[2]), .done(done_w[2]), .orbit_len(len_c),
    .path_record(rec_c), .overflow(ovf_w[2]), .err(err_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the trajectory with plain integer arithmetic
  function automatic exp_t model(longint unsigned num, int bits, int lbits);
    exp_t e;
    longint unsigned n, t, lmax, lim;
    e.len = 0; e.rec = 0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 0;
    lmax = (64'd1 << lbits) - 1;
    lim  = 64'd1 << bits;
    if (num == 0) begin
      e.err = 1'b1;
      return e;
    end
    n = num;
    e.rec = num;
    while (n != 1) begin
      if (e.len == lmax) begin
        e.ovf = 1'b1;
        break;
      end
      t = (n % 2 == 1) ? 3 * n + 1 : n / 2;
      if (t >= lim) begin
        e.ovf = 1'b1;
        break;
      end
      n = t;
      e.len++;
      if (n > e.rec) e.rec = n;
    end
    e.lat = int'(e.len) + 1;
    return e;
  endfunction

  function automatic int sb_size(int i);
    case (i)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t sb_front(int i);
    case (i)
      0:       return sb0[0];
      1:       return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  task automatic sb_push(int i, exp_t e);
    case (i)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(int i);
    case (i)
      0:       void'(sb0.pop_front());
      1:       void'(sb1.pop_front());
      default: void'(sb2.pop_front());
    endcase
  endtask

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: track the accepting edge, then compare when done appears
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin
      exp_t e;
      bit   pend;
      int   cnt;
      pend = 1'b0;
      cnt  = 0;
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          if (pend && sb_size(g) > 0) sb_pop(g);
          pend = 1'b0;
        end else if (acc_v[g]) begin
          pend = 1'b1;
          cnt  = 0;
        end else if (pend) begin
          cnt++;
        end
        @(negedge clk);
        if (pend && sb_size(g) > 0) begin
          e = sb_front(g);
          if (done_w[g]) begin
            chk($sformatf("u%0d latency", g), 64'(cnt), 64'(e.lat));
            chk($sformatf("u%0d orbit_len", g), len_w[g], e.len);
            chk($sformatf("u%0d path_record", g), rec_w[g], e.rec);
            chk($sformatf("u%0d overflow", g), 64'(ovf_w[g]), 64'(e.ovf));
            chk($sformatf("u%0d err", g), 64'(err_w[g]), 64'(e.err));
            chk($sformatf("u%0d busy_in_done", g), 64'(busy_w[g]), 64'd0);
            sb_pop(g);
            pend = 1'b0;
          end else if (cnt >= e.lat) begin
            chk($sformatf("u%0d done_timeout", g), 64'(done_w[g]), 64'd1);
            sb_pop(g);
            pend = 1'b0;
          end else begin
            chk($sformatf("u%0d busy_in_run", g), 64'(busy_w[g]), 64'd1);
          end
        end
      end
    end
  end

  task automatic issue(int i, longint unsigned num, bit accept);
    @(negedge clk);
    start_v[i] = 1'b1;
    num_v[i]   = num;
    acc_v[i]   = accept;
    if (accept) sb_push(i, model(num, BITS_C[i], LBITS_C[i]));
    @(negedge clk);
    start_v[i] = 1'b0;
    acc_v[i]   = 1'b0;
  endtask

  task automatic drain(int i);
    for (int k = 0; k < 2000 && sb_size(i) > 0; k++) @(negedge clk);
    chk($sformatf("u%0d drain", i), 64'(sb_size(i)), 64'd0);
  endtask

  task automatic run(int i, longint unsigned num);
    issue(i, num, 1'b1);
    drain(i);
  endtask

  task automatic check_cleared(int i, string tag);
    chk($sformatf("u%0d %s busy", i, tag), 64'(busy_w[i]), 64'd0);
    chk($sformatf("u%0d %s done", i, tag), 64'(done_w[i]), 64'd0);
    chk($sformatf("u%0d %s orbit_len", i, tag), len_w[i], 64'd0);
    chk($sformatf("u%0d %s path_record", i, tag), rec_w[i], 64'd0);
    chk($sformatf("u%0d %s overflow", i, tag), 64'(ovf_w[i]), 64'd0);
    chk($sformatf("u%0d %s err", i, tag), 64'(err_w[i]), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      num_v[i]   = 0;
      acc_v[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_cleared(i, "reset");
    rst_n = 1'b1;

    // Directed cases from the known trajectories
    run(0, 6);
    run(0, 27);
    run(0, 1);
    run(0, 0);
    run(0, 32'hFFFF_FFFF);
    run(1, 255);
    run(1, 27);
    run(2, 27);
    run(2, 1);

    // Start during RUN is ignored, then a back-to-back start from DONE
    issue(0, 27, 1'b1);
    repeat (4) @(negedge clk);
    issue(0, 6, 1'b0);
    drain(0);
    run(0, 6);
    run(0, 0);
    run(0, 7);

    // Reset mid-computation abandons the result
    issue(0, 27, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared(0, "abort");
    rst_n = 1'b1;
    chk("u0 abort_queue", 64'(sb_size(0)), 64'd0);
    run(0, 6);

    for (int k = 0; k < 25; k++) begin
      if (k % 3 == 0) run(0, longint'($urandom));
      else            run(0, longint'($urandom_range(0, 2000)));
    end
    for (int k = 0; k < 40; k++) run(1, longint'($urandom_range(0, 255)));
    for (int k = 0; k < 20; k++) run(2, longint'($urandom_range(0, 5000)));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
